// File: rtl/bw_mac_accumulator.sv
// bw_mac_accumulator
//   Signed multiply-accumulate back end for the 4-bit Baugh-Wooley multiplier.
//   Sums a group of 8-bit two's-complement products (closed by in_last), then
//   presents sum, beat count and overflow flag on a valid/ready result port.
//
//   Optional feature macro: BW_MAC_SATURATE_EN
//     defined   -> accumulator clamps to the signed ACC_W range on overflow
//     undefined -> accumulator wraps modulo 2^ACC_W
//
// Parameters:
//   ACC_W  accumulator / result width (two's complement, >= 8)
//   CNT_W  beat-counter width
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   prod/in_last valid
//   in_ready   beat accepted this cycle (state ACC)
//   prod       signed product from the multiplier
//   in_last    beat closes the current group
//   out_valid  result registers hold a completed group (state HOLD)
//   out_ready  downstream takes the result
//   out_sum    signed group sum
//   out_count  beats in the group (saturating)
//   out_ovf    overflow occurred somewhere in the group

module bw_mac_accumulator #(
   parameter int ACC_W = 12,
   parameter int CNT_W = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [7:0]         prod,
   input  logic               in_last,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [ACC_W-1:0]   out_sum,
   output logic [CNT_W-1:0]   out_count,
   output logic               out_ovf
);

   localparam logic ST_ACC  = 1'b0;
   localparam logic ST_HOLD = 1'b1;

`ifdef BW_MAC_SATURATE_EN
   localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

   logic             state;
   logic [ACC_W-1:0] acc;
   logic [CNT_W-1:0] cnt;
   logic             ovf;

   logic [ACC_W:0]   sum_ext;
   logic             ovf_now;
   logic [ACC_W-1:0] acc_nxt;
   logic [CNT_W-1:0] cnt_nxt;

   assign in_ready  = (state == ST_ACC);
   assign out_valid = (state == ST_HOLD);

   // One guard bit: a disagreement between the top two bits of the
   // ACC_W+1-bit sum is exactly a signed overflow of the ACC_W result.
   always_comb begin
      sum_ext = {acc[ACC_W-1], acc} + {{(ACC_W-7){prod[7]}}, prod};
      ovf_now = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];
`ifdef BW_MAC_SATURATE_EN
      if (ovf_now)
         acc_nxt = sum_ext[ACC_W] ? ACC_MIN : ACC_MAX;
      else
         acc_nxt = sum_ext[ACC_W-1:0];
`else
      acc_nxt = sum_ext[ACC_W-1:0];
`endif
      cnt_nxt = (cnt == '1) ? cnt : cnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_ACC;
         acc       <= '0;
         cnt       <= '0;
         ovf       <= '0;
         out_sum   <= '0;
         out_count <= '0;
         out_ovf   <= '0;
      end else begin
         case (state)
            ST_ACC: begin
               if (in_valid) begin
                  if (in_last) begin
                     out_sum   <= acc_nxt;
                     out_count <= cnt_nxt;
                     out_ovf   <= ovf | ovf_now;
                     acc       <= '0;
                     cnt       <= '0;
                     ovf       <= '0;
                     state     <= ST_HOLD;
                  end else begin
                     acc <= acc_nxt;
                     cnt <= cnt_nxt;
                     ovf <= ovf | ovf_now;
                  end
               end
            end
            ST_HOLD: begin
               if (out_ready)
                  state <= ST_ACC;
            end
            default: state <= ST_ACC;
         endcase
      end
   end

endmodule

// File: tb/tb_bw_mac_accumulator.sv
// Testbench for bw_mac_accumulator: table-driven groups, hand-written
// multi-cycle sequences, an exhaustive multiplier end-to-end sweep and
// randomized groups checked against an integer reference model.

module tb_bw_mac_accumulator;

   localparam int ACC_W = 12;
   localparam int CNT_W = 5;
   localparam int SMAX  = (1 << (ACC_W-1)) - 1;
   localparam int SMIN  = -(1 << (ACC_W-1));
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [7:0]       prod;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] out_sum;
   logic [CNT_W-1:0] out_count;
   logic             out_ovf;

   int errors = 0;
   int checks = 0;

   bw_mac_accumulator #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .prod      (prod),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_count (out_count),
      .out_ovf   (out_ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   function automatic int ssum();
      return int'($signed(out_sum));
   endfunction

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; prod = '0; out_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Presents a beat at a negedge and returns at the negedge after it is taken.
   task automatic beat(input int p, input bit last);
      int t = 0;
      in_valid = 1'b1;
      prod     = 8'(p);
      in_last  = last;
      while (!in_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (t >= 100) check("in_ready_timeout", 0, 1);
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Waits for a result, optionally stalls dly cycles, then completes it.
   task automatic take(input string nm, input int es, input int ec, input int eo,
                       input int dly);
      int t = 0;
      while (!out_valid && t < 100) begin
         @(negedge clk);
         t++;
      end
      check({nm, "_valid"}, int'(out_valid), 1);
      for (int i = 0; i < dly; i++) begin
         @(negedge clk);
         check({nm, "_held"}, int'(out_valid), 1);
      end
      check({nm, "_sum"}, ssum(), es);
      check({nm, "_count"}, int'(out_count), ec);
      check({nm, "_ovf"}, int'(out_ovf), eo);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({nm, "_in_ready_back"}, int'(in_ready), 1);
      check({nm, "_valid_drop"}, int'(out_valid), 0);
   endtask

   // Behavioural group model: plain integer sum with wrap or clamp per beat.
   task automatic model(input int q[$], output int s, output int c, output int o);
      s = 0; c = 0; o = 0;
      foreach (q[i]) begin
         s = s + q[i];
         if (s > SMAX || s < SMIN) begin
            o = 1;
`ifdef BW_MAC_SATURATE_EN
            s = (s > SMAX) ? SMAX : SMIN;
`else
            s = (s > SMAX) ? s - (1 << ACC_W) : s + (1 << ACC_W);
`endif
         end
         if (c < CMAX) c++;
      end
   endtask

   typedef struct {
      int n;
      int p[4];
      int es;
      int ec;
      int eo;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int q[$];
      int s, c, o, len, hi;

      vecs[0] = '{n:3, p:'{64, 64, -56, 0},    es:72,   ec:3, eo:0};
      vecs[1] = '{n:1, p:'{7, 0, 0, 0},        es:7,    ec:1, eo:0};
      vecs[2] = '{n:4, p:'{-56, -56, -56, -56}, es:-224, ec:4, eo:0};
      vecs[3] = '{n:2, p:'{1, -1, 0, 0},       es:0,    ec:2, eo:0};
      vecs[4] = '{n:1, p:'{-56, 0, 0, 0},      es:-56,  ec:1, eo:0};
      vecs[5] = '{n:4, p:'{64, -1, 3, 10},     es:76,   ec:4, eo:0};

      do_reset();
      check("rst_in_ready", int'(in_ready), 1);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_sum", ssum(), 0);
      check("rst_out_count", int'(out_count), 0);
      check("rst_out_ovf", int'(out_ovf), 0);

      // Table-driven groups; out_valid must be up right after the last beat.
      for (int v = 0; v < 6; v++) begin
         for (int i = 0; i < vecs[v].n; i++)
            beat(vecs[v].p[i], i == vecs[v].n - 1);
         check($sformatf("vec%0d_latency", v), int'(out_valid), 1);
         take($sformatf("vec%0d", v), vecs[v].es, vecs[v].ec, vecs[v].eo, 0);
      end

      // Backpressure: result held 5 cycles while a pending beat waits.
      beat(64, 0); beat(64, 0); beat(-56, 1);
      in_valid = 1'b1; prod = 8'h07; in_last = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check("bp_out_valid", int'(out_valid), 1);
         check("bp_in_ready", int'(in_ready), 0);
         check("bp_sum", ssum(), 72);
         check("bp_count", int'(out_count), 3);
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("bp_exit_in_ready", int'(in_ready), 1);
      beat(7, 1);
      take("bp_g2", 7, 1, 0, 0);

      // Overflow: 32 x +64.
      for (int i = 0; i < 32; i++) beat(64, i == 31);
`ifdef BW_MAC_SATURATE_EN
      take("ovf32", 2047, 31, 1, 0);
`else
      take("ovf32", -2048, 31, 1, 0);
`endif
      // Counter saturation without overflow: 40 beats of +1.
      for (int i = 0; i < 40; i++) beat(1, i == 39);
      take("cnt_sat", 40, 31, 0, 0);

      // Reset mid-group discards the partial sum.
      beat(16, 0); beat(16, 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rstmid_no_valid", int'(out_valid), 0);
      beat(5, 1);
      take("rstmid", 5, 1, 0, 0);

      // Reset while holding a result drops it without handshake.
      beat(9, 1);
      check("rsthold_valid", int'(out_valid), 1);
      rst = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      check("rsthold_dropped", int'(out_valid), 0);
      check("rsthold_in_ready", int'(in_ready), 1);
      check("rsthold_sum_clr", ssum(), 0);

      // Reset wins over a simultaneous input beat.
      in_valid = 1'b1; prod = 8'h11; in_last = 1'b1; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      check("rst_vs_beat", int'(out_valid), 0);

      // End-to-end: all A/B pairs through a signed 4x4 multiply.
      for (int au = 0; au < 16; au++) begin
         int a;
         a = (au > 7) ? au - 16 : au;
         for (int bu = 0; bu < 16; bu++) begin
            int b;
            b = (bu > 7) ? bu - 16 : bu;
            beat(a * b, bu == 15);
         end
         take($sformatf("e2e_a%0d", a), -8 * a, 16, 0, 0);
      end

      // Randomized groups vs. the integer model.
      for (int g = 0; g < 24; g++) begin
         q.delete();
         len = int'($urandom_range(1, 40));
         hi  = g % 2;
         for (int i = 0; i < len; i++) begin
            if (hi != 0) q.push_back(int'($urandom_range(40, 64)));
            else         q.push_back(int'($urandom_range(0, 120)) - 56);
         end
         model(q, s, c, o);
         foreach (q[i]) begin
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            beat(q[i], i == len - 1);
         end
         take($sformatf("rnd%0d", g), s, c, o, int'($urandom_range(0, 3)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
